// File: rtl/abs_rr_sched.sv
// Round-robin arbiter feeding one shared two's-complement absolute-value unit
// with a single-entry valid/ready output stage. Optional: ABS_SIGN_OUT_EN adds res_sign_o.
module abs_rr_sched #(
    parameter int LENGTH  = 10,
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [NUM_REQ*LENGTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    output logic                      res_valid_o,
    output logic [LENGTH-1:0]         res_data_o,
    output logic [ID_W-1:0]           res_id_o,
    input  logic                      res_ready_i
`ifdef ABS_SIGN_OUT_EN
    ,
    output logic                      res_sign_o
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   last_q;
    logic [ID_W-1:0]   gnt;
    logic              found;
    logic              any_valid;
    logic              load;
    logic [LENGTH-1:0] gnt_word;
    logic [LENGTH-1:0] gnt_abs;

    assign any_valid   = |req_valid_i;
    assign res_valid_o = (state_q == FULL);
    assign load        = (~res_valid_o | res_ready_i) & any_valid;

    // Search starts one past the last winner so every requester gets a turn.
    // NOTE: every variable driven here gets a default first; otherwise a path
    // that skips an assignment would infer a latch.
    always_comb begin
        gnt   = last_q;
        found = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!found && req_valid_i[(int'(last_q) + i) % NUM_REQ]) begin
                gnt   = ID_W'((int'(last_q) + i) % NUM_REQ);
                found = 1'b1;
            end
        end
    end

    assign gnt_word    = req_data_i[int'(gnt)*LENGTH +: LENGTH];
    // The most-negative word wraps to itself, which reads correctly as unsigned.
    assign gnt_abs     = gnt_word[LENGTH-1] ? (~gnt_word + LENGTH'(1)) : gnt_word;
    assign req_ready_o = load ? (NUM_REQ'(1) << gnt) : '0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (load) state_d = FULL;
            FULL:    if (res_ready_i && !any_valid) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= EMPTY;
            last_q     <= ID_W'(NUM_REQ - 1);
            res_data_o <= '0;
            res_id_o   <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                last_q     <= gnt;
                res_data_o <= gnt_abs;
                res_id_o   <= gnt;
            end
        end
    end

`ifdef ABS_SIGN_OUT_EN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            res_sign_o <= 1'b0;
        end else if (load) begin
            res_sign_o <= gnt_word[LENGTH-1];
        end
    end
`endif

endmodule
